// File: rtl/video_in_if.sv
// Wishbone classic write-master bus used by the video_in capture DMA.
// Signal names follow the Wishbone master-side convention.
interface video_in_if;
    logic [31:0] p_wb_ADR_O;
    logic [31:0] p_wb_DAT_O;
    logic [31:0] p_wb_DAT_I;
    logic [3:0]  p_wb_SEL_O;
    logic        p_wb_STB_O;
    logic        p_wb_CYC_O;
    logic        p_wb_WE_O;
    logic        p_wb_LOCK_O;
    logic        p_wb_ACK_I;
    logic        p_wb_ERR_I;
    logic        p_wb_RTY_I;

    modport master (
        output p_wb_ADR_O, p_wb_DAT_O, p_wb_SEL_O, p_wb_STB_O,
               p_wb_CYC_O, p_wb_WE_O, p_wb_LOCK_O,
        input  p_wb_DAT_I, p_wb_ACK_I, p_wb_ERR_I, p_wb_RTY_I
    );

    modport slave (
        input  p_wb_ADR_O, p_wb_DAT_O, p_wb_SEL_O, p_wb_STB_O,
               p_wb_CYC_O, p_wb_WE_O, p_wb_LOCK_O,
        output p_wb_DAT_I, p_wb_ACK_I, p_wb_ERR_I, p_wb_RTY_I
    );
endinterface

// File: rtl/video_in.sv
// Camera capture DMA: packs an 8-bit pixel stream into 32-bit words, buffers
// them in a word FIFO and writes them to RAM as Wishbone classic blocks.
//
// DMA states:
//   state  | meaning
//   S_IDLE | waiting for a full block in the FIFO, or a flush of the remainder
//   S_REQ  | load address/data of the first beat, raise CYC/STB
//   S_ACK  | beat on the bus, waiting for ACK/ERR/RTY
//   S_RTY  | STB dropped for one cycle after a retry, same beat re-issued next
module video_in #(
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int BLOCK_SIZE   = 32,
    parameter int FIFO_WORDS   = 16
) (
    input  logic        p_clk,
    input  logic        p_reset,
    input  logic        pixel_en,
    input  logic        frame_valid,
    input  logic        line_valid,
    input  logic [7:0]  pixel_in,
    input  logic [31:0] cfg_addr,
    input  logic        cfg_addr_valid,
    output logic        irq,
    input  logic        irq_ack,
    output logic        overflow,
    output logic        bus_error,
    video_in_if.master  wb
);

    localparam int TOTAL     = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int CNT_W     = $clog2(TOTAL + 1);
    localparam int BLK_WORDS = BLOCK_SIZE / 4;
    localparam int PTR_W     = (FIFO_WORDS > 1) ? $clog2(FIFO_WORDS) : 1;
    localparam int LVL_W     = $clog2(FIFO_WORDS + 1);

    localparam logic [CNT_W-1:0] TOTAL_C  = CNT_W'(TOTAL);
    localparam logic [LVL_W-1:0] BLK_C    = LVL_W'(BLK_WORDS);
    localparam logic [LVL_W-1:0] FULL_C   = LVL_W'(FIFO_WORDS);
    localparam logic [LVL_W-1:0] ONE_C    = LVL_W'(1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_RTY} dma_state_t;

    // capture front end
    logic             fv_prev;
    logic             armed;
    logic             capturing;
    logic             flush;
    logic [31:0]      pending_addr;
    logic [31:0]      wr_addr;
    logic [CNT_W-1:0] pix_cnt;
    logic [23:0]      pack;

    logic             fv_rise, fv_fall, start, cap_active, cap, push_evt, frame_end;
    logic [CNT_W-1:0] cnt_base, cnt_inc;
    logic [31:0]      push_word;

    // word FIFO
    logic [31:0]      mem [FIFO_WORDS];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_inc, rd_ptr_inc;
    logic [LVL_W-1:0] level;
    logic             fifo_full, push_ok;
    logic [31:0]      head, next_head;

    // DMA engine
    dma_state_t       state, state_nxt;
    logic [LVL_W-1:0] beats, beats_nxt;
    logic             cyc_q, stb_q, cyc_nxt, stb_nxt;
    logic [31:0]      adr_q, dat_q, adr_nxt, dat_nxt;
    logic             pop, set_irq, flush_clr, set_berr, adv;

    logic             unused_dat;
    assign unused_dat = ^wb.p_wb_DAT_I;

    always_comb begin
        fv_rise    = pixel_en && frame_valid && !fv_prev;
        fv_fall    = pixel_en && !frame_valid && fv_prev;
        start      = fv_rise && armed;
        // the rising-edge cycle itself may already carry the first pixel
        cap_active = start || capturing;
        cnt_base   = start ? '0 : pix_cnt;
        cap        = pixel_en && frame_valid && line_valid && cap_active &&
                     (cnt_base < TOTAL_C);
        cnt_inc    = cnt_base + 1'b1;
        push_evt   = cap && (cnt_base[1:0] == 2'd3);
        push_word  = {pixel_in, pack};
        frame_end  = cap_active && ((cap && (cnt_inc == TOTAL_C)) || fv_fall);
    end

    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            fv_prev      <= 1'b0;
            armed        <= 1'b0;
            capturing    <= 1'b0;
            flush        <= 1'b0;
            pending_addr <= '0;
            wr_addr      <= '0;
            pix_cnt      <= '0;
            pack         <= '0;
            overflow     <= 1'b0;
            bus_error    <= 1'b0;
            irq          <= 1'b0;
        end else begin
            if (pixel_en) fv_prev <= frame_valid;

            if (start) begin
                armed     <= 1'b0;
                capturing <= 1'b1;
                pix_cnt   <= '0;
                overflow  <= 1'b0;
                wr_addr   <= pending_addr;
            end else if (pop) begin
                wr_addr <= wr_addr + 32'd4;
            end

            // a strobe after the rising edge re-arms for the following frame
            if (cfg_addr_valid) begin
                pending_addr <= cfg_addr;
                armed        <= 1'b1;
            end

            if (cap) begin
                pix_cnt <= cnt_inc;
                if (cnt_base[1:0] != 2'd3) pack[{cnt_base[1:0], 3'b000} +: 8] <= pixel_in;
            end

            if (push_evt && fifo_full) overflow <= 1'b1;

            if (flush_clr) flush <= 1'b0;
            if (frame_end) begin
                capturing <= 1'b0;
                pack      <= '0;
                flush     <= 1'b1;
            end

            if (set_berr) bus_error <= 1'b1;

            if (set_irq)      irq <= 1'b1;
            else if (irq_ack) irq <= 1'b0;
        end
    end

    always_comb begin
        fifo_full  = (level == FULL_C);
        push_ok    = push_evt && !fifo_full;
        wr_ptr_inc = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        rd_ptr_inc = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        head       = mem[rd_ptr];
        next_head  = mem[rd_ptr_inc];
    end

    always_ff @(posedge p_clk) begin
        if (push_ok) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr_inc;
            if (pop)     rd_ptr <= rd_ptr_inc;
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            state <= S_IDLE;
            beats <= '0;
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
        end else begin
            state <= state_nxt;
            beats <= beats_nxt;
            cyc_q <= cyc_nxt;
            stb_q <= stb_nxt;
            adr_q <= adr_nxt;
            dat_q <= dat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        beats_nxt = beats;
        cyc_nxt   = cyc_q;
        stb_nxt   = stb_q;
        adr_nxt   = adr_q;
        dat_nxt   = dat_q;
        pop       = 1'b0;
        set_irq   = 1'b0;
        flush_clr = 1'b0;
        set_berr  = 1'b0;
        // ERR outranks RTY, which outranks ACK
        adv       = wb.p_wb_ERR_I || (!wb.p_wb_RTY_I && wb.p_wb_ACK_I);

        case (state)
            S_IDLE: begin
                if (level >= BLK_C) begin
                    beats_nxt = BLK_C;
                    state_nxt = S_REQ;
                end else if (flush && (level != '0)) begin
                    beats_nxt = level;
                    state_nxt = S_REQ;
                end else if (flush) begin
                    set_irq   = 1'b1;
                    flush_clr = 1'b1;
                end
            end
            S_REQ: begin
                cyc_nxt   = 1'b1;
                stb_nxt   = 1'b1;
                adr_nxt   = wr_addr;
                dat_nxt   = head;
                state_nxt = S_ACK;
            end
            S_ACK: begin
                if (adv) begin
                    set_berr  = wb.p_wb_ERR_I;
                    pop       = 1'b1;
                    beats_nxt = beats - 1'b1;
                    if (beats == ONE_C) begin
                        cyc_nxt   = 1'b0;
                        stb_nxt   = 1'b0;
                        state_nxt = S_IDLE;
                    end else begin
                        adr_nxt = wr_addr + 32'd4;
                        dat_nxt = next_head;
                    end
                end else if (wb.p_wb_RTY_I) begin
                    stb_nxt   = 1'b0;
                    state_nxt = S_RTY;
                end
            end
            S_RTY: begin
                stb_nxt   = 1'b1;
                state_nxt = S_ACK;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign wb.p_wb_ADR_O  = adr_q;
    assign wb.p_wb_DAT_O  = dat_q;
    assign wb.p_wb_SEL_O  = 4'hF;
    assign wb.p_wb_STB_O  = stb_q;
    assign wb.p_wb_CYC_O  = cyc_q;
    assign wb.p_wb_WE_O   = cyc_q;
    assign wb.p_wb_LOCK_O = 1'b0;

endmodule
